// File: rtl/sram_rd_pkg.sv
// Shared types and constants for the SRAM read streamer.
//   rd_state_e        : controller state (idle, issuing reads, draining the buffer)
//   RD_BUF_DEPTH      : output buffer depth, also the credit limit
//   RD_INFLIGHT_DEPTH : cycles from issuing a read to capturing its data
package sram_rd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain
  } rd_state_e;

  localparam int unsigned RD_BUF_DEPTH      = 4;
  localparam int unsigned RD_INFLIGHT_DEPTH = 2;

endpackage

// File: rtl/sram_rd_streamer_if.sv
// Bundle of the streamer's control, output stream and SRAM port signals.
//   master : the streamer (drives busy/done, the stream and the SRAM controls)
//   slave  : the environment (drives start/base_addr/len, out_ready and sram_q)
interface sram_rd_streamer_if #(
  parameter int unsigned num = 2048,
  parameter int unsigned bw  = 32
);
  localparam int unsigned AW = $clog2(num);

  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [bw-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [bw-1:0] sram_q;

  modport master (
    input  start, base_addr, len, out_ready, sram_q,
    output busy, done, out_data, out_valid, sram_cen, sram_wen, sram_a
  );

  modport slave (
    output start, base_addr, len, out_ready, sram_q,
    input  busy, done, out_data, out_valid, sram_cen, sram_wen, sram_a
  );

endinterface

// File: rtl/stream_fifo.sv
// Small register FIFO with simultaneous push/pop at any occupancy.
//   i_clk, i_rst : clock, asynchronous active-high reset (storage cleared)
//   i_push/i_data: write request and data
//   i_pop        : read request (head is consumed)
//   o_data       : head entry, taken from storage registers only
//   o_valid      : FIFO not empty
module stream_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_data,
  output logic             o_valid
);
  localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_rd;
  logic [PW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign w_pop  = i_pop && (r_cnt != '0);
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_push = i_push && ((r_cnt != CW'(Depth)) || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < int'(Depth); i++) r_mem[i] <= '0;
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ptr_inc(r_wr);
      end
      if (w_pop) r_rd <= ptr_inc(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_valid = (r_cnt != '0);

endmodule

// File: rtl/sram_rd_streamer.sv
// Reads len consecutive SRAM words from base_addr (wrapping modulo num) and
// streams them out in order on a valid/ready port.
//   CLK, reset : clock, asynchronous active-high reset
//   bus        : control (start/base_addr/len/busy/done), output stream
//                (out_data/out_valid/out_ready) and SRAM port (cen/wen/a/q)
// Credit = buffered words + reads in flight; issue only while credit allows,
// so the buffer can never overflow under back-pressure.
module sram_rd_streamer
  import sram_rd_pkg::*;
#(
  parameter int unsigned num = 2048,
  parameter int unsigned bw  = 32
) (
  input logic                CLK,
  input logic                reset,
  sram_rd_streamer_if.master bus
);
  localparam int unsigned AW = $clog2(num);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(RD_BUF_DEPTH + 1);

  rd_state_e                    r_state;
  logic [AW-1:0]                r_addr;
  logic [LW-1:0]                r_len;
  logic [LW-1:0]                r_issued;
  logic [LW-1:0]                r_accepted;
  logic [CW-1:0]                r_credit;
  logic [RD_INFLIGHT_DEPTH-1:0] r_inflight;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_sram_cen;
  logic [AW-1:0]                r_sram_a;

  logic          w_pop;
  logic          w_issue;
  logic [AW-1:0] w_addr_next;
  logic [bw-1:0] w_fifo_data;
  logic          w_fifo_valid;

  assign w_pop       = w_fifo_valid && bus.out_ready;
  assign w_addr_next = (r_addr == AW'(num - 1)) ? '0 : r_addr + AW'(1);
  // A pop in this cycle frees a slot, so issue may resume at full credit.
  assign w_issue     = (r_state == StIssue) && (r_issued < r_len) &&
                       ((r_credit < CW'(RD_BUF_DEPTH)) || w_pop);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_accepted <= '0;
      r_credit   <= '0;
      r_inflight <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sram_cen <= 1'b1;
      r_sram_a   <= '0;
    end else begin
      r_done     <= 1'b0;
      // Bit 0: address registered on the SRAM pins; top bit: data on sram_q.
      r_inflight <= {r_inflight[RD_INFLIGHT_DEPTH-2:0], w_issue};
      r_credit   <= r_credit + CW'(w_issue) - CW'(w_pop);
      if (w_pop) r_accepted <= r_accepted + LW'(1);

      unique case (r_state)
        StIdle: begin
          r_sram_cen <= 1'b1;
          if (bus.start) begin
            r_addr     <= bus.base_addr;
            r_len      <= bus.len;
            r_issued   <= '0;
            r_accepted <= '0;
            r_busy     <= 1'b1;
            r_state    <= (bus.len == '0) ? StDrain : StIssue;
          end
        end
        StIssue: begin
          r_sram_cen <= ~w_issue;
          if (w_issue) begin
            r_sram_a <= r_addr;
            r_addr   <= w_addr_next;
            r_issued <= r_issued + LW'(1);
            if (r_issued + LW'(1) == r_len) r_state <= StDrain;
          end
        end
        StDrain: begin
          r_sram_cen <= 1'b1;
          // Finish on the edge that consumes the last word.
          if (r_accepted + LW'(w_pop) == r_len) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  stream_fifo #(
    .Depth (RD_BUF_DEPTH),
    .Width (bw)
  ) u_buf (
    .i_clk   (CLK),
    .i_rst   (reset),
    .i_push  (r_inflight[RD_INFLIGHT_DEPTH-1]),
    .i_data  (bus.sram_q),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid)
  );

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.out_data  = w_fifo_data;
  assign bus.out_valid = w_fifo_valid;
  assign bus.sram_cen  = r_sram_cen;
  assign bus.sram_wen  = 1'b1;  // read-only initiator
  assign bus.sram_a    = r_sram_a;

endmodule

// File: tb/tb_sram_rd_streamer.sv
module tb_sram_rd_streamer;
  localparam int unsigned NUM = 2048;
  localparam int unsigned BW  = 32;
  localparam int unsigned AW  = $clog2(NUM);

  logic CLK   = 1'b0;
  logic reset = 1'b1;

  sram_rd_streamer_if #(.num(NUM), .bw(BW)) bus ();

  sram_rd_streamer #(.num(NUM), .bw(BW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // SRAM model: address registered at the edge where CEN is low, data after it.
  logic [BW-1:0] mem [NUM];
  always @(posedge CLK) if (bus.sram_cen === 1'b0) bus.sram_q <= mem[bus.sram_a];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Observed behaviour, collected between edges.
  logic [BW-1:0] got[$];
  logic [AW-1:0] addrs[$];
  int cnt_cen, cnt_acc, cnt_done, max_diff, wen_bad;
  int first_valid_cyc, first_acc_cyc, last_acc_cyc, done_cyc;

  always @(negedge CLK) begin
    if (!reset) begin
      if (bus.sram_wen !== 1'b1) wen_bad++;
      if (bus.sram_cen === 1'b0) begin
        cnt_cen++;
        addrs.push_back(bus.sram_a);
      end
      if (cnt_cen - cnt_acc > max_diff) max_diff = cnt_cen - cnt_acc;
      if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        got.push_back(bus.out_data);
        if (cnt_acc == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        cnt_acc++;
      end
      if (bus.done === 1'b1) begin
        cnt_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    got.delete();
    addrs.delete();
    cnt_cen = 0; cnt_acc = 0; cnt_done = 0; max_diff = 0; wen_bad = 0;
    first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " busy"}, 64'(bus.busy), 0);
    chk({tag, " done"}, 64'(bus.done), 0);
    chk({tag, " out_valid"}, 64'(bus.out_valid), 0);
    chk({tag, " out_data"}, 64'(bus.out_data), 0);
    chk({tag, " sram_cen"}, 64'(bus.sram_cen), 1);
    chk({tag, " sram_wen"}, 64'(bus.sram_wen), 1);
    chk({tag, " sram_a"}, 64'(bus.sram_a), 0);
  endtask

  // Pulse start for one cycle; e0 = cycle count just after the sampling edge.
  task automatic start_xfer(input int base, input int len, output int e0);
    @(posedge CLK); #1;
    clear_mon();
    bus.start     = 1'b1;
    bus.base_addr = base[AW-1:0];
    bus.len       = len[AW:0];
    e0            = cyc + 1;
    @(posedge CLK); #1;
    bus.start = 1'b0;
  endtask

  bit rnd_ready = 0;
  int stall = 0;

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && cnt_done == 0; i++) begin
      @(posedge CLK); #1;
      if (rnd_ready) begin
        if (stall > 0) begin
          bus.out_ready = 1'b0;
          stall--;
        end else if ($urandom_range(0, 5) == 0) begin
          bus.out_ready = 1'b0;
          stall = 4;
        end else begin
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
    chk({tag, " done seen"}, 64'(cnt_done > 0), 1);
    bus.out_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // Reference: word k of a transfer is mem[(base + k) mod NUM].
  task automatic check_words(input string tag, input int base, input int len);
    chk({tag, " word count"}, 64'(got.size()), 64'(len));
    for (int k = 0; k < len && k < got.size(); k++)
      chk($sformatf("%s word %0d", tag, k), 64'(got[k]), 64'(mem[(base + k) % NUM]));
  endtask

  initial begin
    int e0;
    int len;
    int base;
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.out_ready = 1'b0;
    clear_mon();
    for (int i = 0; i < int'(NUM); i++) mem[i] = BW'(i);

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;

    // Basic transfer, consumer always ready
    bus.out_ready = 1'b1;
    start_xfer(10, 8, e0);
    wait_done("basic", 100);
    check_words("basic", 10, 8);
    chk("basic first valid latency", 64'(first_valid_cyc - e0), 3);
    chk("basic back-to-back", 64'(last_acc_cyc - first_acc_cyc), 7);
    chk("basic done pulses", 64'(cnt_done), 1);
    chk("basic done after last accept", 64'(done_cyc - last_acc_cyc), 1);
    chk("basic reads issued", 64'(cnt_cen), 8);
    chk("basic wen low seen", 64'(wen_bad), 0);
    chk("basic busy after done", 64'(bus.busy), 0);

    // Address wrap
    start_xfer(2046, 4, e0);
    wait_done("wrap", 100);
    chk("wrap addr count", 64'(addrs.size()), 4);
    for (int k = 0; k < 4 && k < addrs.size(); k++)
      chk($sformatf("wrap addr %0d", k), 64'(addrs[k]), 64'((2046 + k) % NUM));
    check_words("wrap", 2046, 4);

    // Random contents, random back-pressure with stalls
    for (int i = 0; i < int'(NUM); i++) mem[i] = $urandom;
    for (int r = 0; r < 4; r++) begin
      len  = (r == 0) ? 16 : $urandom_range(1, 40);
      base = (r == 1) ? int'(NUM) - 3 : $urandom_range(0, NUM - 1);
      rnd_ready = 1;
      start_xfer(base, len, e0);
      wait_done($sformatf("rand%0d", r), 3000);
      rnd_ready = 0;
      check_words($sformatf("rand%0d", r), base, len);
      chk($sformatf("rand%0d credit bound", r), 64'(max_diff <= 4), 1);
      chk($sformatf("rand%0d reads issued", r), 64'(cnt_cen), 64'(len));
      chk($sformatf("rand%0d done pulses", r), 64'(cnt_done), 1);
    end

    // Full back-pressure: issue stops at 4 outstanding; start while busy is ignored
    bus.out_ready = 1'b0;
    start_xfer(20, 6, e0);
    repeat (4) @(posedge CLK);
    #1;
    bus.start = 1'b1; bus.base_addr = AW'(500); bus.len = (AW + 1)'(9);
    @(posedge CLK); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    chk("stall reads capped", 64'(cnt_cen), 4);
    chk("stall nothing accepted", 64'(got.size()), 0);
    chk("stall out_valid held", 64'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    wait_done("stall", 100);
    check_words("stall", 20, 6);
    chk("stall reads issued", 64'(cnt_cen), 6);
    chk("stall done pulses", 64'(cnt_done), 1);

    // Zero-length transfer
    start_xfer(5, 0, e0);
    chk("len0 busy", 64'(bus.busy), 1);
    wait_done("len0", 20);
    chk("len0 no reads", 64'(cnt_cen), 0);
    chk("len0 done timing", 64'(done_cyc - e0), 1);
    chk("len0 busy after", 64'(bus.busy), 0);
    chk("len0 no words", 64'(got.size()), 0);

    // Reset in the middle of a transfer
    start_xfer(300, 10, e0);
    for (int i = 0; i < 50 && cnt_acc < 3; i++) begin
      @(negedge CLK); #1;
    end
    chk("midreset reached 3 words", 64'(cnt_acc >= 3), 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge CLK); @(posedge CLK); #1;
    reset = 1'b0;
    start_xfer(100, 2, e0);
    wait_done("after reset", 100);
    repeat (6) @(posedge CLK);
    #1;
    check_words("after reset", 100, 2);
    chk("after reset reads issued", 64'(cnt_cen), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
